// File: rtl/seq_multiplier.sv
// Iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU): multiplies operand magnitudes
// BITS_PER_CYCLE multiplier bits at a time, then applies the sign and selects a product half.
module seq_multiplier #(
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        flush,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        signed_a,
   input  logic        signed_b,
   input  logic        high,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);

   localparam int N  = 32 / BITS_PER_CYCLE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t state, state_next;

   logic [63:0]   mcand_q;
   logic [31:0]   mag_b_q;
   logic [63:0]   acc_q;
   logic [CW-1:0] cnt_q;
   logic          neg_q;
   logic          high_q;

   logic          neg_a, neg_b;
   logic [31:0]   mag_a_in, mag_b_in;
   logic          accept, last;
   logic [BITS_PER_CYCLE-1:0] digit;
   logic [63:0]   addend, acc_sum, product;

   // Negating 0x80000000 yields 0x80000000, which read unsigned is exactly 2^31.
   assign neg_a    = signed_a & a[31];
   assign neg_b    = signed_b & b[31];
   assign mag_a_in = neg_a ? (~a + 32'd1) : a;
   assign mag_b_in = neg_b ? (~b + 32'd1) : b;

   assign accept = (state != BUSY) && start && !flush;
   assign last   = (state == BUSY) && (cnt_q == '0);

   // The multiplicand is pre-shifted each iteration so the addend needs no variable shift.
   assign digit   = mag_b_q[BITS_PER_CYCLE-1:0];
   assign addend  = mcand_q * {{(64-BITS_PER_CYCLE){1'b0}}, digit};
   assign acc_sum = acc_q + addend;
   assign product = neg_q ? (~acc_sum + 64'd1) : acc_sum;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         mcand_q <= '0;
         mag_b_q <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         high_q  <= 1'b0;
         result  <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            mcand_q <= {32'd0, mag_a_in};
            mag_b_q <= mag_b_in;
            acc_q   <= '0;
            cnt_q   <= CW'(N - 1);
            neg_q   <= neg_a ^ neg_b;
            high_q  <= high;
         end else if (state == BUSY) begin
            acc_q   <= acc_sum;
            mcand_q <= mcand_q << BITS_PER_CYCLE;
            mag_b_q <= mag_b_q >> BITS_PER_CYCLE;
            cnt_q   <= cnt_q - CW'(1);
            // The final sum is folded into the result on the same edge that enters DONE.
            if (last && !flush)
               result <= high_q ? product[63:32] : product[31:0];
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE, DONE: state_next = accept ? BUSY : IDLE;
         BUSY: begin
            if (flush)
               state_next = IDLE;
            else if (cnt_q == '0)
               state_next = DONE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state == BUSY);
   assign done = (state == DONE);

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Iterative 32x32 multiplier in the execute stage. It consumes the decode-to-execute latch fields mult, mult_half, mult_signed_a, mult_signed_b, rdat1 and rdat2.
- Implements RV32M MUL, MULH, MULHSU and MULHU with a fixed, deterministic latency.
- Raises busy so the hazard logic stalls the decode-to-execute latch (en=0) until the result is ready. done is a one-cycle pulse that lets execute forward the result to the writeback path.

Parameters:
- BITS_PER_CYCLE, 1, multiplier bits retired per iteration. Legal values: 1, 2, 4, 8. Defines N = 32/BITS_PER_CYCLE iteration cycles.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE. Driven by mult & latch-valid.
- flush  input  1  abort the in-flight operation. Driven by the pipeline flush.
- a  input  32  operand rs1 (rdat1).
- b  input  32  operand rs2 (rdat2).
- signed_a  input  1  treat a as two's complement.
- signed_b  input  1  treat b as two's complement.
- high  input  1  0 = return product[31:0], 1 = return product[63:32].
- busy  output  1  operation in progress; stall request.
- done  output  1  one-cycle result-valid pulse.
- result  output  32  selected product half.

Behaviour:
- Reset: state=IDLE, busy=0, done=0, result=0, all internal accumulators and counters cleared. Reset mid-operation discards the operation and produces no done.
- States: IDLE, BUSY, DONE.
  - IDLE or DONE, start=1, flush=0: go to BUSY.
  - IDLE or DONE, start=0 or flush=1: go to / stay in IDLE.
  - BUSY, flush=1: go to IDLE, no done.
  - BUSY, last iteration: go to DONE.
  - BUSY, otherwise: stay in BUSY.
  - DONE lasts exactly one cycle unless a new start is accepted, which goes directly to BUSY.
- Accept cycle (cycle 0):
  - Latch |a| and |b|. A magnitude is the operand itself when unsigned or non-negative; otherwise its 33-bit two's-complement negation. 0x80000000 signed becomes magnitude 2^31, with no overflow.
  - Latch neg = (signed_a & a[31]) ^ (signed_b & b[31]), and latch high.
  - Clear the 64-bit accumulator; load the iteration counter with N-1.
- BUSY (cycles 1..N):
  - Each cycle adds |a| * (the next BITS_PER_CYCLE bits of |b|, LSB-first), shifted into the accumulator, and decrements the counter.
  - Arithmetic is unsigned with a 64-bit accumulator. Carries out of bit 63 are impossible and need no handling.
- DONE (cycle N+1):
  - product = neg ? -acc : acc, modulo 2^64.
  - result = high ? product[63:32] : product[31:0], registered.
  - done=1, busy=0.
- Latency: start sampled in cycle 0 gives done=1 in cycle N+1 (33 for the default). busy=1 exactly during cycles 1..N. No early-out on zero operands.
- result holds its value after DONE until the next DONE. It is not cleared on flush or in IDLE.
- Operand inputs are ignored after the accept cycle; changes on a/b/sign/high during BUSY have no effect.
- start while BUSY is ignored; the requester must hold start until it sees done, then deassert. If start remains high in DONE, a new operation starts in that same cycle. Back-to-back issue therefore costs N+1 cycles per op.
- flush and start together in IDLE or DONE: flush wins, state goes to IDLE.
- done never asserts for a flushed or reset operation.

Test Plan:
- Reset, then MUL a=7, b=6, high=0, both unsigned -> busy high for cycles 1..32, done=1 only in cycle 33, result=0x0000002A.
- MULH a=b=0xFFFFFFFF, both signed, high=1 -> result=0x00000000. Repeat with high=0 -> result=0x00000001.
- MULHU a=b=0xFFFFFFFF, unsigned, high=1 -> result=0xFFFFFFFE. Then MULH a=b=0x80000000, signed, high=1 -> result=0x40000000.
- MULHSU a=0xFFFFFFFF (signed), b=0xFFFFFFFF (unsigned), high=1 -> result=0xFFFFFFFF. Same operands with high=0 -> result=0x00000001.
- Start op; assert flush in cycle 10 -> busy=0 from cycle 11, no done pulse, and result keeps its prior value. Repeat using rst in cycle 10 -> result=0.
- Hold start high across two ops with BITS_PER_CYCLE=4 (N=8), first 3*5 then 0x10000*0x10000 with high=1 -> done in cycles 9 and 18 with results 15 and 1. Change a/b mid-BUSY -> results unaffected.
